// File: rtl/mac_acc16.sv
// ---------------------------------------------------------------------------
// mac_acc16 -- saturating frame accumulator for 16-bit unsigned products
//
// Sums a frame of products from an upstream 8x8 multiplier into an ACC_W-bit
// accumulator that saturates at all-ones.  A frame ends after LEN products or
// on a product marked with in_last.  The result is then held until the
// consumer takes it.
//
// Parameters
//   LEN    products per frame (1..255)
//   ACC_W  accumulator width (17..32)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous frame abort, wins over any handshake
//   in_valid   a product is presented
//   in_ready   block accepts a product (ACCUM state)
//   in_prod    16-bit unsigned product
//   in_last    early end-of-frame marker (only meaningful on a beat)
//   out_valid  frame result available (DONE state)
//   out_ready  consumer accepts the result
//   out_sum    saturated sum (running value while accumulating)
//   out_count  number of products accepted in the frame
//   out_ovf    saturation occurred in the frame
// ---------------------------------------------------------------------------
module mac_acc16 #(
    parameter int unsigned LEN   = 8,
    parameter int unsigned ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_ovf
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    localparam logic [7:0] LEN_B = 8'(LEN);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W:0]     sum_ext;
    logic               carry;
    logic [ACC_W-1:0]   acc_sat;
    logic [7:0]         cnt_inc;
    logic               frame_end;

    // One extra bit catches the carry out of the accumulator; once the flag
    // is set the accumulator is already all-ones, so forcing '1 keeps it there.
    assign sum_ext   = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, in_prod};
    assign carry     = sum_ext[ACC_W];
    assign acc_sat   = (carry || ovf_q) ? '1 : sum_ext[ACC_W-1:0];
    assign cnt_inc   = cnt_q + 8'd1;
    assign frame_end = (cnt_inc == LEN_B) || in_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        in_ready  = (state_q == ST_ACCUM);
        out_valid = (state_q == ST_DONE);

        if (clr) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_ACCUM: begin
                    if (in_valid) begin
                        acc_d = acc_sat;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | carry;
                        if (frame_end) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
    end

    // Outputs always show the registered state: running values in ACCUM,
    // frozen frame result in DONE.
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: doc/mac_acc16.md
MAC_ACC16 -- requirements
Module: mac_acc16

Interface
REQ-001 The block SHALL have parameter LEN, default 8: products per frame, range 1..255.
REQ-002 The block SHALL have parameter ACC_W, default 24: accumulator width, range 17..32.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous frame abort.
REQ-006 The block SHALL have port in_valid, input, 1 bit: a product is presented.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a product.
REQ-008 The block SHALL have port in_prod, input, 16 bits: unsigned product from the upstream 8x8 unsigned multiplier (O[15:0]).
REQ-009 The block SHALL have port in_last, input, 1 bit: early end-of-frame marker.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a frame result is available.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port out_sum, output, ACC_W bits: saturated frame sum.
REQ-013 The block SHALL have port out_count, output, 8 bits: number of products in the frame.
REQ-014 The block SHALL have port out_ovf, output, 1 bit: saturation occurred in the frame.

Function
REQ-015 The block SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-016 A beat SHALL occur on a rising edge with in_valid=1 and in_ready=1; without a beat, no state changes except by clr.
REQ-017 On a beat, acc SHALL become min(acc + in_prod, 2^ACC_W-1), count SHALL increment, and ovf SHALL be set if the unsaturated sum exceeds 2^ACC_W-1.
REQ-018 ovf SHALL be sticky within a frame; once saturated, acc SHALL stay all-ones.
REQ-019 A beat with count+1==LEN or in_last=1 SHALL move the block ACCUM->DONE; out_valid SHALL be 1 the next cycle, and out_sum SHALL include that beat.
REQ-020 Latency from the final beat edge to out_valid=1 SHALL be exactly 1 cycle.
REQ-021 in_last SHALL be ignored on cycles with no beat.
REQ-022 In DONE, out_sum, out_count and out_ovf SHALL hold stable until out_valid&&out_ready.
REQ-023 On out_valid&&out_ready, the block SHALL clear acc, count and ovf to 0 and return to ACCUM; in_ready SHALL become 1 the next cycle, with no same-cycle bypass.
REQ-024 In ACCUM, out_sum/out_count/out_ovf SHALL show the running acc/count/ovf.
REQ-025 clr=1 SHALL, on the edge, zero acc, count and ovf and force ACCUM in any state.
REQ-026 clr SHALL win over a simultaneous beat or output handshake; the product is dropped, or the DONE result is discarded.
REQ-027 With LEN=1, every beat SHALL complete a frame.
REQ-028 out_ready SHALL be ignored in ACCUM.
REQ-029 in_prod SHALL be zero-extended to ACC_W.

Reset
REQ-030 rst_n=0 SHALL immediately, with no clock required, force ACCUM, acc=0, count=0, ovf=0, in_ready=1, out_valid=0, out_sum=0, out_count=0 and out_ovf=0.
REQ-031 Reset asserted mid-frame or in DONE SHALL discard all partial or pending results.
REQ-032 After deassertion, the first beat SHALL be accepted on the first rising edge with in_valid=1.

Verification
REQ-033 The bench SHALL cover: LEN=4, products 100, 200, 300, 400 on consecutive cycles, out_ready=1 -> out_valid one cycle after the 4th beat, out_sum=1000, out_count=4, out_ovf=0, then in_ready=1.
REQ-034 The bench SHALL cover: LEN=8, products 7 then 9 with in_last=1 on the 2nd -> out_sum=16, out_count=2.
REQ-035 The bench SHALL cover: ACC_W=17, LEN=4, three beats of 0xFFFF with in_last on the 3rd -> out_sum=131071, out_ovf=1, out_count=3.
REQ-036 The bench SHALL cover: frame complete, out_ready=0 for 5 cycles -> out_valid/out_sum stable and in_ready=0 throughout; in_valid held high is not consumed; out_ready=1 -> accepted, next frame starts.
REQ-037 The bench SHALL cover: clr asserted with a beat of 500 after an acc of 50 -> acc=0, count=0; the next beat of 3 gives out_sum=3 at frame end.
REQ-038 The bench SHALL cover: rst_n pulsed low asynchronously between edges mid-frame (count=2) -> out_sum=0, out_count=0, in_ready=1 before the next edge.
